spi_slave_param: RTL and testbench

- Parametrised successor of the team's SPI slave front end for the single-port RAM.
- Deserialises fixed-length command frames from MOSI into a (DATA_WIDTH+2)-bit word for the RAM: 2-bit command plus payload.
- Serialises RAM read data back on MISO, waiting for the RAM's tx handshake with a timeout.
- New over the previous generation: configurable width, configurable bit order, frame-error reporting, read-data timeout and an explicit read-address/read-data ordering check.

---
 rtl/spi_slave_param_if.sv | 24 ++
 rtl/spi_slave_param.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_param.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_param_if.sv
// rtl/spi_slave_param_if.sv - SPI slave / RAM-side signal bundle for spi_slave_param
interface spi_slave_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SS_n;
    logic                  MOSI;
    logic                  MISO;
    logic [DATA_WIDTH+1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output MISO, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  MISO, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parametrised SPI slave front end for the single-port RAM
module spi_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 1,
    parameter int TX_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_param_if.slave bus
);
    localparam int W  = DATA_WIDTH + 2;
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] LAST_RX  = CW'(W - 1);
    localparam logic [CW-1:0] TX_BITS  = CW'(DATA_WIDTH);
    localparam logic [7:0]    TO_LAST  = 8'(TX_TIMEOUT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RECV    = 3'd1;
    localparam logic [2:0] WAIT_TX = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [7:0]            to_cnt;
    logic [W-1:0]          shreg;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic                  rd_addr_seen;
    logic                  miso_q;
    logic [W-1:0]          rx_data_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;

    logic [W-1:0]          word_next;
    logic [1:0]            cmd_next;

    // Bit that leaves the transmit register first for the configured order.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    // Transmit register after the leading bit has been consumed.
    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
    endfunction

    // Shift register contents including this edge's MOSI bit, and the command
    // formed from the first two bits in arrival order once the word is full.
    always_comb begin
        word_next = '0;
        cmd_next  = '0;
        if (MSB_FIRST != 0) begin
            word_next = {shreg[W-2:0], bus.MOSI};
            cmd_next  = word_next[W-1:W-2];
        end else begin
            word_next = {bus.MOSI, shreg[W-1:1]};
            cmd_next  = {word_next[0], word_next[1]};
        end
    end

    // Frame state machine: receive, optional read-data wait and transmit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            shreg        <= '0;
            tx_sr        <= '0;
            rd_addr_seen <= 1'b0;
            miso_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state != IDLE && bus.SS_n) begin
                // Slave select released: a partial word is an error, later aborts are silent.
                state       <= IDLE;
                bit_cnt     <= '0;
                to_cnt      <= '0;
                miso_q      <= 1'b0;
                frame_err_q <= (state == RECV);
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.SS_n) begin
                            shreg   <= word_next;
                            bit_cnt <= CW'(1);
                            state   <= RECV;
                        end
                    end
                    RECV: begin
                        shreg   <= word_next;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_RX) begin
                            rx_data_q <= word_next;
                            bit_cnt   <= '0;
                            if (cmd_next == 2'b11) begin
                                if (rd_addr_seen) begin
                                    rx_valid_q   <= 1'b1;
                                    rd_addr_seen <= 1'b0;
                                    to_cnt       <= '0;
                                    state        <= WAIT_TX;
                                end else begin
                                    frame_err_q <= 1'b1;
                                    state       <= DONE;
                                end
                            end else begin
                                rx_valid_q <= 1'b1;
                                if (cmd_next == 2'b10) begin
                                    rd_addr_seen <= 1'b1;
                                end
                                state <= DONE;
                            end
                        end
                    end
                    WAIT_TX: begin
                        if (bus.tx_valid) begin
                            miso_q  <= first_bit(bus.tx_data);
                            tx_sr   <= shift_out(bus.tx_data);
                            bit_cnt <= CW'(1);
                            to_cnt  <= '0;
                            state   <= SEND;
                        end else if (to_cnt == TO_LAST) begin
                            frame_err_q <= 1'b1;
                            miso_q      <= 1'b0;
                            to_cnt      <= '0;
                            state       <= DONE;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                    SEND: begin
                        if (bit_cnt == TX_BITS) begin
                            miso_q  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            miso_q  <= first_bit(tx_sr);
                            tx_sr   <= shift_out(tx_sr);
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - randomized frame-level check of spi_slave_param, both bit orders
module tb_spi_slave_param;
    localparam int DW   = 8;
    localparam int W    = DW + 2;
    localparam int TO0  = 16;
    localparam int TO1  = 5;
    localparam int MAXE = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    bit           seen;
    logic [W-1:0] last_rx [2];

    spi_slave_param_if #(.DATA_WIDTH(DW)) bus0 ();
    spi_slave_param_if #(.DATA_WIDTH(DW)) bus1 ();

    spi_slave_param #(.DATA_WIDTH(DW), .MSB_FIRST(1), .TX_TIMEOUT(TO0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    spi_slave_param #(.DATA_WIDTH(DW), .MSB_FIRST(0), .TX_TIMEOUT(TO1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int timeout_of(input int d);
        return (d == 0) ? TO0 : TO1;
    endfunction

    // Arrival-ordered frame bits from a word written first-bit-leftmost.
    function automatic logic [63:0] mkbits(input logic [W-1:0] v);
        logic [63:0] r;
        r = {$urandom, $urandom};
        for (int k = 0; k < W; k++) r[k] = v[W-1-k];
        return r;
    endfunction

    task automatic drive(input logic ss, input logic mosi, input logic tv, input logic [DW-1:0] td);
        bus0.SS_n = ss;  bus1.SS_n = ss;
        bus0.MOSI = mosi; bus1.MOSI = mosi;
        bus0.tx_valid = tv; bus1.tx_valid = tv;
        bus0.tx_data = td;  bus1.tx_data = td;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " d0 outputs"}, {bus0.MISO, bus0.rx_valid, bus0.frame_err, bus0.busy, 22'(bus0.rx_data)}, 32'd0);
        check_eq({tag, " d1 outputs"}, {bus1.MISO, bus1.rx_valid, bus1.frame_err, bus1.busy, 22'(bus1.rx_data)}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs(tag);
        rst = 1'b0;
        seen = 1'b0;
        last_rx[0] = '0;
        last_rx[1] = '0;
    endtask

    // One frame: SS_n low for edges 0..len-1, tx_valid pulse at edge tv (-1 none),
    // optional reset pulse at edge rst_e (only used with rst_e == len).
    task automatic run_frame(input string name, input logic [63:0] bits, input int len,
                             input int tv, input logic [DW-1:0] txd, input int rst_e);
        int           ne;
        int           te;
        bit           acc;
        logic [1:0]   cmd;
        logic [W-1:0] word [2];
        bit           e_rv [2][MAXE];
        bit           e_fe [2][MAXE];
        bit           e_mi [2][MAXE];
        bit           e_bz [2][MAXE];
        logic         o_rv [2];
        logic         o_fe [2];
        logic         o_mi [2];
        logic         o_bz [2];
        logic [W-1:0] o_rx [2];

        ne = len + 2;
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < MAXE; e++) begin
                e_rv[d][e] = 1'b0;
                e_fe[d][e] = 1'b0;
                e_mi[d][e] = 1'b0;
                e_bz[d][e] = (e < len);
            end

        cmd = {bits[0], bits[1]};
        for (int k = 0; k < W; k++) begin
            word[0][W-1-k] = bits[k];
            word[1][k]     = bits[k];
        end

        if (len < W) begin
            if (rst_e != len)
                for (int d = 0; d < 2; d++) e_fe[d][len] = 1'b1;
        end else begin
            acc = (cmd == 2'b11) && seen;
            for (int d = 0; d < 2; d++) begin
                last_rx[d] = word[d];
                if (cmd == 2'b11 && !seen) e_fe[d][W-1] = 1'b1;
                else                        e_rv[d][W-1] = 1'b1;
                if (acc) begin
                    te = W - 1 + timeout_of(d);
                    if (tv >= W && tv <= te && tv < len) begin
                        for (int j = 0; j < DW; j++)
                            if (tv + j < len)
                                e_mi[d][tv+j] = (d == 0) ? txd[DW-1-j] : txd[j];
                    end else if (te < len) begin
                        e_fe[d][te] = 1'b1;
                    end
                end
            end
            if (cmd == 2'b10) seen = 1'b1;
            if (acc)          seen = 1'b0;
        end
        if (rst_e == len) begin
            seen = 1'b0;
            last_rx[0] = '0;
            last_rx[1] = '0;
        end

        for (int e = 0; e < ne; e++) begin
            drive((e < len) ? 1'b0 : 1'b1, bits[e % 64], (e == tv) ? 1'b1 : 1'b0,
                  (e == tv) ? txd : DW'($urandom));
            rst = (e == rst_e) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            o_rv[0] = bus0.rx_valid;  o_rv[1] = bus1.rx_valid;
            o_fe[0] = bus0.frame_err; o_fe[1] = bus1.frame_err;
            o_mi[0] = bus0.MISO;      o_mi[1] = bus1.MISO;
            o_bz[0] = bus0.busy;      o_bz[1] = bus1.busy;
            o_rx[0] = bus0.rx_data;   o_rx[1] = bus1.rx_data;
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("%s d%0d e%0d rx_valid", name, d, e), 32'(o_rv[d]), 32'(e_rv[d][e]));
                check_eq($sformatf("%s d%0d e%0d frame_err", name, d, e), 32'(o_fe[d]), 32'(e_fe[d][e]));
                check_eq($sformatf("%s d%0d e%0d MISO", name, d, e), 32'(o_mi[d]), 32'(e_mi[d][e]));
                check_eq($sformatf("%s d%0d e%0d busy", name, d, e), 32'(o_bz[d]), 32'(e_bz[d][e]));
                if (e_rv[d][e])
                    check_eq($sformatf("%s d%0d e%0d rx_data", name, d, e), 32'(o_rx[d]), 32'(word[d]));
            end
        end
        check_eq({name, " d0 rx_data held"}, 32'(bus0.rx_data), 32'(last_rx[0]));
        check_eq({name, " d1 rx_data held"}, 32'(bus1.rx_data), 32'(last_rx[1]));
    endtask

    initial begin
        int len;
        int tv;
        drive(1'b1, 1'b0, 1'b0, '0);
        do_reset("reset");

        run_frame("wr_addr", mkbits(10'b00_1010_0101), W, -1, '0, -1);
        check_eq("wr_addr d0 word", 32'(bus0.rx_data), 32'h0A5);

        run_frame("rd_addr", mkbits(10'b10_0011_1100), W, -1, '0, -1);
        check_eq("rd_addr d0 word", 32'(bus0.rx_data), 32'h23C);
        run_frame("rd_data", mkbits(10'b11_0000_0000), 22, 11, 8'hA5, -1);
        check_eq("rd_data d0 word", 32'(bus0.rx_data), 32'h300);

        do_reset("reset2");
        run_frame("rd_noaddr", mkbits({2'b11, 8'($urandom)}), 12, -1, '0, -1);

        run_frame("rd_addr2", mkbits({2'b10, 8'($urandom)}), W, -1, '0, -1);
        run_frame("rd_timeout", mkbits({2'b11, 8'($urandom)}), 30, -1, '0, -1);

        run_frame("short", mkbits(10'b01_1101_0000), 7, -1, '0, -1);

        run_frame("lsb_addr", mkbits(10'b1010000001), W, -1, '0, -1);
        check_eq("lsb_addr d1 word", 32'(bus1.rx_data), 32'h205);
        run_frame("rst_send", mkbits({2'b11, 8'($urandom)}), 14, 11, 8'h3C, 14);
        run_frame("after_rst", mkbits({2'b11, 8'($urandom)}), W, -1, '0, -1);

        for (int i = 0; i < 200; i++) begin
            len = ($urandom % 5 == 0) ? $urandom_range(1, W - 1) : $urandom_range(W, W + DW + 22);
            tv  = ($urandom % 4 == 0) ? -1 : $urandom_range(W, W + TO0 + 4);
            run_frame($sformatf("rnd%0d", i), {$urandom, $urandom}, len, tv, DW'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
